// File: rtl/keyb_scan_fifo.sv
// rtl/keyb_scan_fifo.sv - matrix keypad scanner, debouncer and press/release event FIFO (optional auto-repeat: KEYB_REPEAT_EN)
module keyb_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CNT    = 50000,
  parameter int FIFO_DEPTH = 4,
  parameter int REP_DELAY  = 25000000,
  parameter int REP_RATE   = 5000000,
  localparam int KW        = $clog2(ROWS * COLS)
) (
  input  logic            clk,
  input  logic            reset,
  output logic [COLS-1:0] cols,
  input  logic [ROWS-1:0] rows,
  output logic            key_valid,
  input  logic            key_ready,
  output logic [KW-1:0]   key_code,
  output logic            key_press,
  output logic            any_btn,
  output logic            overflow,
  input  logic            clr_ovf
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int NW = $clog2(DEB_CNT + 1);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_e;

  state_e          state_q, state_d;
  logic [ROWS-1:0] rows_m_q, rows_s_q;
  logic            run_q;
  logic [CW-1:0]   col_q, col_d, next_col;
  logic [DW-1:0]   div_q, div_d;
  logic [NW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [ROWS-1:0] pat_q, pat_d;
  logic [KW-1:0]   code_q, code_d;
  logic [RW-1:0]   row_idx;
  logic            one_hot;
  logic            push, push_press;

  logic [KW:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_q, rd_q;
  logic [AW:0]     count_q;
  logic            ovf_q;
  logic            full, pop, do_write, drop;
  logic [KW:0]     head;

`ifdef KEYB_REPEAT_EN
  localparam int PW = $clog2((REP_DELAY > REP_RATE ? REP_DELAY : REP_RATE) + 1);
  logic [PW-1:0]   rep_q, rep_d;
  logic            rep_first_q, rep_first_d;
`endif

  assign cols     = run_q ? (COLS'(1) << col_q) : '0;
  assign any_btn  = |rows_s_q;
  assign one_hot  = (rows_s_q != '0) && ((rows_s_q & (rows_s_q - ROWS'(1))) == '0);
  assign next_col = (col_q == CW'(COLS - 1)) ? '0 : col_q + CW'(1);
  assign cnt_inc  = cnt_q + NW'(1);

  // Index of the (single) active row in the synchronised return lines
  always_comb begin
    row_idx = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rows_s_q[r]) row_idx = RW'(r);
    end
  end

  // Scan / debounce FSM next-state and event generation
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    code_d     = code_q;
    push       = 1'b0;
    push_press = 1'b0;
`ifdef KEYB_REPEAT_EN
    rep_d       = rep_q;
    rep_first_d = rep_first_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (run_q) begin
          if (div_q == DW'(SCAN_DIV - 1)) begin
            div_d = '0;
            if (one_hot) begin
              pat_d   = rows_s_q;
              code_d  = KW'(col_q) * KW'(ROWS) + KW'(row_idx);
              cnt_d   = '0;
              state_d = DEB_PRESS;
            end else begin
              col_d = next_col;
            end
          end else begin
            div_d = div_q + DW'(1);
          end
        end
      end
      DEB_PRESS: begin
        if (rows_s_q != pat_q) begin
          state_d = SCAN;
          col_d   = next_col;
          div_d   = '0;
          cnt_d   = '0;
        end else if (cnt_inc == NW'(DEB_CNT)) begin
          push       = 1'b1;
          push_press = 1'b1;
          state_d    = HELD;
          cnt_d      = '0;
`ifdef KEYB_REPEAT_EN
          rep_d       = '0;
          rep_first_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HELD: begin
        if (rows_s_q == '0) begin
          state_d = DEB_REL;
          cnt_d   = '0;
`ifdef KEYB_REPEAT_EN
          rep_d       = '0;
          rep_first_d = 1'b1;
        end else if ((rep_first_q && (rep_q + PW'(1) == PW'(REP_DELAY))) ||
                     (!rep_first_q && (rep_q + PW'(1) == PW'(REP_RATE)))) begin
          push        = 1'b1;
          push_press  = 1'b1;
          rep_d       = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_d = rep_q + PW'(1);
`endif
        end
      end
      DEB_REL: begin
        if (rows_s_q != '0) begin
          state_d = HELD;
        end else if (cnt_inc == NW'(DEB_CNT)) begin
          push    = 1'b1;
          state_d = SCAN;
          col_d   = next_col;
          div_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = SCAN;
    endcase
  end

  // Row synchroniser and FSM/scan state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_m_q <= '0;
      rows_s_q <= '0;
      run_q    <= 1'b0;
      state_q  <= SCAN;
      col_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      pat_q    <= '0;
      code_q   <= '0;
    end else begin
      rows_m_q <= rows;
      rows_s_q <= rows_m_q;
      run_q    <= 1'b1;
      state_q  <= state_d;
      col_q    <= col_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      pat_q    <= pat_d;
      code_q   <= code_d;
    end
  end

`ifdef KEYB_REPEAT_EN
  // Auto-repeat timer, only counts while the key is held
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q       <= '0;
      rep_first_q <= 1'b1;
    end else begin
      rep_q       <= rep_d;
      rep_first_q <= rep_first_d;
    end
  end
`endif

  // Event FIFO: a full FIFO still accepts a push when the head is popped in the same cycle
  assign key_valid = (count_q != '0);
  assign full      = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign pop       = key_valid && key_ready;
  assign do_write  = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign head      = mem_q[rd_q];
  assign key_press = key_valid & head[KW];
  assign key_code  = key_valid ? head[KW-1:0] : '0;
  assign overflow  = ovf_q;

  // FIFO storage, no reset needed since reads are gated by key_valid
  always_ff @(posedge clk) begin
    if (do_write) mem_q[wr_q] <= {push_press, code_q};
  end

  // FIFO pointers, occupancy and sticky overflow (a drop wins over clr_ovf)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_write) wr_q <= wr_q + AW'(1);
      if (pop)      rd_q <= rd_q + AW'(1);
      case ({do_write, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop)         ovf_q <= 1'b1;
      else if (clr_ovf) ovf_q <= 1'b0;
    end
  end

endmodule
